rollover_logger: RTL and testbench
==================================

// Module: rollover_logger
// PURPOSE
//  Downstream stage of the 4-bit up/down/down-by-3/load counter. Consumes the counter's
//  Q, mode and rollover pulse, and extends the count with an EXT_W-bit upper digit.
//  Logs every rollover event (timestamp, mode, Q) into a small FIFO. A consumer drains
//  the FIFO over a valid/ready handshake.
// PARAMETERS
//  CNT_W      4   width of the upstream counter value q_in
//  EXT_W      12  width of the extended (upper) rollover counter
//  TS_W       16  width of the free-running timestamp
//  FIFO_DEPTH 4   event FIFO entries; power of 2, >=2
// PORTS
//  clk         in   1                  rising-edge clock
//  reset       in   1                  asynchronous, active-high; clears all state
//  enable      in   1                  same enable the upstream counter sees
//  modo        in   2                  upstream mode: 00 up, 01 down, 10 down-3, 11 load
//  q_in        in   CNT_W              upstream counter value after update
//  rco_in      in   1                  rollover pulse: 1 cycle wide, stable around posedge
//  ext_count   out  EXT_W              extended upper count
//  full_count  out  EXT_W+CNT_W        {ext_count, q_in}, combinational concat
//  ev_valid    out  1                  FIFO not empty
//  ev_ready    in   1                  consumer accepts head entry
//  ev_data     out  TS_W+2+CNT_W       {timestamp, modo, q_in} of head entry
//  ev_level    out  clog2(DEPTH)+1     current FIFO occupancy
//  overflow    out  1                  sticky: an event was dropped
//  drop_count  out  8                  saturating count of dropped events
// BEHAVIOUR
//  - Reset (async assert): ext_count=0, timestamp=0, FIFO empty, ev_valid=0,
//    ev_level=0, overflow=0, drop_count=0. ev_data is don't-care while ev_valid=0.
//  - Timestamp increments every cycle, regardless of enable, and wraps modulo 2^TS_W.
//  - event = enable & rco_in, sampled at posedge. When enable=0, rco_in is ignored.
//  - On event, ext_count update:
//      modo 00: +1, wraps modulo 2^EXT_W
//      modo 01 or 10: -1, wraps 0 -> all-ones
//      modo 11: no change and no FIFO push (a load never rolls over)
//  - Push: on event with modo!=11, write {timestamp, modo, q_in}. The timestamp is the
//    value before this cycle's increment.
//  - FIFO latency: a push into an empty FIFO gives ev_valid=1 on the next cycle.
//    There is no fall-through.
//  - Pop: when ev_valid & ev_ready at posedge, the head is removed. ev_ready with
//    ev_valid=0 has no effect.
//  - Simultaneous push and pop:
//      not full: occupancy unchanged, both take effect
//      full: the pop frees the slot and the push is accepted, no drop
//  - Push while full and no pop: the entry is dropped and ext_count still updates.
//    overflow<=1 and stays set until reset. drop_count += 1, saturating at 255.
//  - Reset asserted mid-operation clears everything immediately. Entries are lost and
//    ev_valid drops asynchronously.
//  - The pointer/count FSM is implicit: EMPTY -> PARTIAL -> FULL by occupancy.
//    ev_valid = (level!=0). Full = (level==FIFO_DEPTH).
// STRUCTURE
//  - Shared package/header (scoreboard_defs): MODE_UP=2'b00, MODE_DN=2'b01,
//    MODE_DN3=2'b10, MODE_LD=2'b11, and the event field widths/offsets.
//  - Sub-module event_fifo: synchronous FIFO, parameterised width/depth, with
//    push/pop/level/full. Top level holds ext_count, timestamp, event decode and
//    drop logic.
// TESTING
//  1. Reset, modo=00, enable=1, 16 ups so q wraps and rco pulses once -> ext_count=1;
//     one entry {ts=15, 00, q=0}; ev_valid high 1 cycle after the pulse.
//  2. From ext_count=0, modo=01 rollover -> ext_count=0xFFF; entry mode=01, q=0xF.
//     Then modo=10 rollover from q=1 -> ext_count=0xFFE; entry q=0xE.
//  3. ev_ready=0, 6 rollovers -> ev_level=4, overflow=1, drop_count=2, ext_count
//     advanced by 6. Drain -> 4 entries in push order with increasing timestamps.
//  4. FIFO full, push and pop in the same cycle -> level stays 4, no drop, new entry
//     at tail.
//  5. modo=11 with rco_in forced 1, and enable=0 with rco_in=1 -> no ext_count
//     change, no push.
//  6. Assert reset async mid-drain with level=3 -> ev_valid=0 and ext_count=0 before
//     the next clk edge. After release, timestamp restarts at 0.

Source files
------------

// File: rtl/rollover_logger_pkg.sv
// Shared definitions for the rollover logger: counter modes, event word layout,
// default widths and the occupancy states of the event FIFO.
package rollover_logger_pkg;

  typedef enum logic [1:0] {
    MODE_UP  = 2'b00,
    MODE_DN  = 2'b01,
    MODE_DN3 = 2'b10,
    MODE_LD  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    FIFO_EMPTY,
    FIFO_PARTIAL,
    FIFO_FULL
  } fifo_state_e;

  localparam int CNT_W_DEF      = 4;
  localparam int EXT_W_DEF      = 12;
  localparam int TS_W_DEF       = 16;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int MODE_W         = 2;
  localparam int DROP_W         = 8;

  // Event word is {timestamp, mode, q}; q sits at bit 0, mode just above it.
  function automatic int ev_width(input int ts_w, input int cnt_w);
    return ts_w + MODE_W + cnt_w;
  endfunction

  function automatic int ev_mode_lsb(input int cnt_w);
    return cnt_w;
  endfunction

  function automatic int ev_ts_lsb(input int cnt_w);
    return cnt_w + MODE_W;
  endfunction

endpackage

// File: rtl/rollover_logger_if.sv
// Consumer-side event stream: valid/ready handshake carrying the head FIFO entry.
interface rollover_logger_if #(
  parameter int DATA_W = 22
);
  logic              ev_valid;
  logic              ev_ready;
  logic [DATA_W-1:0] ev_data;

  modport master (output ev_valid, output ev_data, input ev_ready);
  modport slave  (input ev_valid, input ev_data, output ev_ready);
endinterface

// File: rtl/rollover_logger_event_fifo.sv
// Synchronous event FIFO without fall-through; a pop frees a slot for a push in
// the same cycle even when full.
//   state        | meaning
//   FIFO_EMPTY   | level == 0, nothing to present
//   FIFO_PARTIAL | 0 < level < DEPTH
//   FIFO_FULL    | level == DEPTH, a push without a pop is dropped
module event_fifo
  import rollover_logger_pkg::*;
#(
  parameter int WIDTH = 22,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     valid_o,
  output logic                     drop_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  fifo_state_e      state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok, pop_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FIFO_EMPTY;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: entries are only visible through the occupancy.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    pop_ok   = pop_i && (state_q != FIFO_EMPTY);
    push_ok  = push_i && ((state_q != FIFO_FULL) || pop_ok);
    drop_o   = push_i && !push_ok;

    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_ok && !pop_ok)      level_d = level_q + LVL_W'(1);
    else if (pop_ok && !push_ok) level_d = level_q - LVL_W'(1);

    case (state_q)
      FIFO_EMPTY: begin
        if (push_ok) state_d = FIFO_PARTIAL;
      end
      FIFO_PARTIAL: begin
        if (push_ok && !pop_ok && (level_q == LVL_W'(DEPTH - 1)))
          state_d = FIFO_FULL;
        else if (pop_ok && !push_ok && (level_q == LVL_W'(1)))
          state_d = FIFO_EMPTY;
      end
      FIFO_FULL: begin
        if (pop_ok && !push_ok) state_d = FIFO_PARTIAL;
      end
      default: state_d = FIFO_EMPTY;
    endcase
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign level_o   = level_q;
  assign valid_o   = (state_q != FIFO_EMPTY);

endmodule

// File: rtl/rollover_logger.sv
// Extends the upstream 4-bit counter with an upper rollover digit, timestamps every
// rollover and queues it for a valid/ready consumer, tracking dropped events.
module rollover_logger
  import rollover_logger_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int EXT_W      = EXT_W_DEF,
  parameter int TS_W       = TS_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [MODE_W-1:0]               modo,
  input  logic [CNT_W-1:0]                q_in,
  input  logic                            rco_in,
  output logic [EXT_W-1:0]                ext_count,
  output logic [EXT_W+CNT_W-1:0]          full_count,
  rollover_logger_if.master               ev,
  output logic [$clog2(FIFO_DEPTH):0]     ev_level,
  output logic                            overflow,
  output logic [DROP_W-1:0]               drop_count
);

  localparam int EV_W = ev_width(TS_W, CNT_W);

  logic [EXT_W-1:0]  ext_q, ext_d;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic              ovf_q, ovf_d;
  logic [DROP_W-1:0] drops_q, drops_d;
  logic              ev_hit, ev_push, fifo_drop;
  logic [EV_W-1:0]   ev_word, fifo_rd_data;

  assign ev_hit  = enable && rco_in;
  assign ev_push = ev_hit && (modo != MODE_LD);

  always_comb begin
    ev_word = '0;
    ev_word[CNT_W-1:0]                    = q_in;
    ev_word[ev_mode_lsb(CNT_W) +: MODE_W] = modo;
    ev_word[ev_ts_lsb(CNT_W) +: TS_W]     = ts_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext_q   <= '0;
      ts_q    <= '0;
      ovf_q   <= 1'b0;
      drops_q <= '0;
    end else begin
      ext_q   <= ext_d;
      ts_q    <= ts_d;
      ovf_q   <= ovf_d;
      drops_q <= drops_d;
    end
  end

  always_comb begin
    ext_d   = ext_q;
    ts_d    = ts_q + TS_W'(1);
    ovf_d   = ovf_q || fifo_drop;
    drops_d = drops_q;
    if (ev_hit) begin
      case (modo)
        MODE_UP:           ext_d = ext_q + EXT_W'(1);
        MODE_DN, MODE_DN3: ext_d = ext_q - EXT_W'(1);
        MODE_LD:           ext_d = ext_q;
        default:           ext_d = ext_q;
      endcase
    end
    // Dropped-event count holds at all-ones rather than wrapping.
    if (fifo_drop && (drops_q != {DROP_W{1'b1}})) drops_d = drops_q + DROP_W'(1);
  end

  event_fifo #(
    .WIDTH (EV_W),
    .DEPTH (FIFO_DEPTH)
  ) u_event_fifo (
    .clk       (clk),
    .rst       (reset),
    .push_i    (ev_push),
    .pop_i     (ev.ev_ready),
    .wr_data_i (ev_word),
    .rd_data_o (fifo_rd_data),
    .level_o   (ev_level),
    .valid_o   (ev.ev_valid),
    .drop_o    (fifo_drop)
  );

  assign ev.ev_data  = fifo_rd_data;
  assign ext_count   = ext_q;
  assign full_count  = {ext_q, q_in};
  assign overflow    = ovf_q;
  assign drop_count  = drops_q;

endmodule

// File: tb/tb_rollover_logger.sv
// Directed bench for rollover_logger: vector table plus hand-written sequences for
// wrap, saturation and asynchronous reset.
module tb_rollover_logger;
  import rollover_logger_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  modo = 2'b00;
  logic [3:0]  q_in = 4'h0;
  logic        rco_in = 1'b0;
  logic [11:0] ext_count;
  logic [15:0] full_count;
  logic [2:0]  ev_level;
  logic        overflow;
  logic [7:0]  drop_count;

  int errors = 0;
  int checks = 0;

  rollover_logger_if #(.DATA_W(22)) ev_if ();

  rollover_logger dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .modo       (modo),
    .q_in       (q_in),
    .rco_in     (rco_in),
    .ext_count  (ext_count),
    .full_count (full_count),
    .ev         (ev_if),
    .ev_level   (ev_level),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [1:0]  modo;
    logic [3:0]  q;
    logic        rco;
    logic        rdy;
    logic [11:0] ext;
    logic        valid;
    logic [2:0]  lvl;
    logic        ovf;
    logic [7:0]  drops;
    logic [15:0] ts;
    logic [1:0]  dmode;
    logic [3:0]  dq;
  } vec_t;

  vec_t vt [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic en, input logic [1:0] m, input logic [3:0] q,
                      input logic rco, input logic rdy);
    enable          = en;
    modo            = m;
    q_in            = q;
    rco_in          = rco;
    ev_if.ev_ready  = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b0, 2'b00, 4'h0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk("rst.ext", 32'(ext_count), 32'h0);
    chk("rst.valid", 32'(ev_if.ev_valid), 32'h0);
    chk("rst.level", 32'(ev_level), 32'h0);
    chk("rst.ovf", 32'(overflow), 32'h0);
    chk("rst.drops", 32'(drop_count), 32'h0);
    chk("rst.full_count", 32'(full_count), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    ev_if.ev_ready = 1'b0;

    // en modo q rco rdy | ext valid lvl ovf drops | head ts mode q
    vt[0]  = '{1'b1,2'b01,4'hF,1'b1,1'b0, 12'hFFF,1'b1,3'd1,1'b0,8'd0, 16'd0, 2'b01,4'hF};
    vt[1]  = '{1'b1,2'b10,4'hE,1'b1,1'b0, 12'hFFE,1'b1,3'd2,1'b0,8'd0, 16'd0, 2'b01,4'hF};
    vt[2]  = '{1'b0,2'b00,4'h0,1'b0,1'b1, 12'hFFE,1'b1,3'd1,1'b0,8'd0, 16'd1, 2'b10,4'hE};
    vt[3]  = '{1'b0,2'b00,4'h0,1'b0,1'b1, 12'hFFE,1'b0,3'd0,1'b0,8'd0, 16'd0, 2'b00,4'h0};
    vt[4]  = '{1'b1,2'b00,4'h0,1'b1,1'b0, 12'hFFF,1'b1,3'd1,1'b0,8'd0, 16'd4, 2'b00,4'h0};
    vt[5]  = '{1'b1,2'b00,4'h1,1'b1,1'b0, 12'h000,1'b1,3'd2,1'b0,8'd0, 16'd4, 2'b00,4'h0};
    vt[6]  = '{1'b1,2'b00,4'h2,1'b1,1'b0, 12'h001,1'b1,3'd3,1'b0,8'd0, 16'd4, 2'b00,4'h0};
    vt[7]  = '{1'b1,2'b00,4'h3,1'b1,1'b0, 12'h002,1'b1,3'd4,1'b0,8'd0, 16'd4, 2'b00,4'h0};
    vt[8]  = '{1'b1,2'b00,4'h4,1'b1,1'b0, 12'h003,1'b1,3'd4,1'b1,8'd1, 16'd4, 2'b00,4'h0};
    vt[9]  = '{1'b1,2'b00,4'h5,1'b1,1'b0, 12'h004,1'b1,3'd4,1'b1,8'd2, 16'd4, 2'b00,4'h0};
    vt[10] = '{1'b1,2'b00,4'h6,1'b1,1'b1, 12'h005,1'b1,3'd4,1'b1,8'd2, 16'd5, 2'b00,4'h1};
    vt[11] = '{1'b0,2'b00,4'h0,1'b0,1'b1, 12'h005,1'b1,3'd3,1'b1,8'd2, 16'd6, 2'b00,4'h2};
    vt[12] = '{1'b0,2'b00,4'h0,1'b0,1'b1, 12'h005,1'b1,3'd2,1'b1,8'd2, 16'd7, 2'b00,4'h3};
    vt[13] = '{1'b0,2'b00,4'h0,1'b0,1'b1, 12'h005,1'b1,3'd1,1'b1,8'd2, 16'd10,2'b00,4'h6};
    vt[14] = '{1'b0,2'b00,4'h0,1'b0,1'b1, 12'h005,1'b0,3'd0,1'b1,8'd2, 16'd0, 2'b00,4'h0};
    vt[15] = '{1'b1,2'b11,4'h7,1'b1,1'b0, 12'h005,1'b0,3'd0,1'b1,8'd2, 16'd0, 2'b00,4'h0};
    vt[16] = '{1'b0,2'b00,4'h0,1'b1,1'b0, 12'h005,1'b0,3'd0,1'b1,8'd2, 16'd0, 2'b00,4'h0};
    vt[17] = '{1'b0,2'b01,4'h0,1'b1,1'b0, 12'h005,1'b0,3'd0,1'b1,8'd2, 16'd0, 2'b00,4'h0};

    #1;
    do_reset();

    // Sixteen up-counts: q wraps to 0 on the 16th with a single rco pulse.
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 2'b00, 4'(i), (i == 16), 1'b0);
      chk($sformatf("up%0d.valid", i), 32'(ev_if.ev_valid), 32'(i == 16));
      chk($sformatf("up%0d.ext", i), 32'(ext_count), (i == 16) ? 32'h1 : 32'h0);
    end
    chk("up.level", 32'(ev_level), 32'h1);
    chk("up.data", 32'(ev_if.ev_data), 32'({16'd15, 2'b00, 4'h0}));
    chk("up.full_count", 32'(full_count), 32'h0010);
    step(1'b0, 2'b00, 4'h0, 1'b0, 1'b1);
    chk("up.pop_valid", 32'(ev_if.ev_valid), 32'h0);

    do_reset();
    for (int i = 0; i < 18; i++) begin
      v = vt[i];
      step(v.en, v.modo, v.q, v.rco, v.rdy);
      chk($sformatf("v%0d.ext", i), 32'(ext_count), 32'(v.ext));
      chk($sformatf("v%0d.full_count", i), 32'(full_count), 32'({v.ext, v.q}));
      chk($sformatf("v%0d.valid", i), 32'(ev_if.ev_valid), 32'(v.valid));
      chk($sformatf("v%0d.level", i), 32'(ev_level), 32'(v.lvl));
      chk($sformatf("v%0d.ovf", i), 32'(overflow), 32'(v.ovf));
      chk($sformatf("v%0d.drops", i), 32'(drop_count), 32'(v.drops));
      if (v.valid)
        chk($sformatf("v%0d.data", i), 32'(ev_if.ev_data), 32'({v.ts, v.dmode, v.dq}));
    end

    // 260 further ups with no consumer: 4 fill, 256 dropped, counter pins at 255.
    for (int k = 0; k < 260; k++) step(1'b1, 2'b00, 4'(k), 1'b1, 1'b0);
    chk("sat.drops", 32'(drop_count), 32'd255);
    chk("sat.level", 32'(ev_level), 32'd4);
    chk("sat.ovf", 32'(overflow), 32'h1);
    chk("sat.ext", 32'(ext_count), 32'h109);
    chk("sat.head", 32'(ev_if.ev_data), 32'({16'd18, 2'b00, 4'h0}));
    step(1'b0, 2'b00, 4'h0, 1'b0, 1'b1);
    chk("sat.pop_level", 32'(ev_level), 32'd3);
    chk("sat.pop_head", 32'(ev_if.ev_data), 32'({16'd19, 2'b00, 4'h1}));

    // Asynchronous reset between clock edges while draining.
    #2;
    reset = 1'b1;
    #1;
    chk("arst.valid", 32'(ev_if.ev_valid), 32'h0);
    chk("arst.ext", 32'(ext_count), 32'h0);
    chk("arst.level", 32'(ev_level), 32'h0);
    chk("arst.ovf", 32'(overflow), 32'h0);
    chk("arst.drops", 32'(drop_count), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1'b1, 2'b00, 4'h9, 1'b1, 1'b0);
    chk("post.ext", 32'(ext_count), 32'h1);
    chk("post.level", 32'(ev_level), 32'h1);
    chk("post.data", 32'(ev_if.ev_data), 32'({16'd0, 2'b00, 4'h9}));
    step(1'b0, 2'b00, 4'h0, 1'b0, 1'b1);
    chk("post.pop_valid", 32'(ev_if.ev_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
